// File: rtl/wdog_timer_param.sv
// wdog_timer_param: parametrised watchdog timer, Avalon-MM slave (16-bit data, 3-bit word address).
// Software-programmable period, early-warning threshold interrupt, stretched reset-request pulse.
// Optional windowed mode is compiled in with `define WDOG_TIMER_WINDOW_EN; without it kicks are
// always accepted and STATUS.EARLY reads 0.
//
// Bus handshake: there is no wait-state; a write is accepted in the cycle where
// chipselect=1 and write_n=0, and readdata presents mux(address) one clk later, every cycle.
module wdog_timer_param #(
  parameter int unsigned COUNTER_WIDTH      = 27,
  parameter logic [31:0] DEFAULT_PERIOD     = 32'h05F5E0FF,
  parameter int unsigned RESET_PULSE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        resetrequest
);

  localparam int unsigned CW = COUNTER_WIDTH;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t       DEF_PERIOD = DEFAULT_PERIOD[CW-1:0];
  localparam logic [7:0] PULSE_LOAD = 8'(RESET_PULSE_CYCLES);

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PER_L   = 3'd2;
  localparam logic [2:0] A_PER_H   = 3'd3;
  localparam logic [2:0] A_SNAP_L  = 3'd4;
  localparam logic [2:0] A_SNAP_H  = 3'd5;
  localparam logic [2:0] A_THR_L   = 3'd6;
  localparam logic [2:0] A_THR_H   = 3'd7;

  // Merge one 16-bit half into a CW-bit register; bits at or above CW are dropped.
  function automatic cnt_t write_half(input cnt_t cur, input logic hi, input logic [15:0] wd);
    logic [31:0] w;
    w = 32'(cur);
    if (hi) w[31:16] = wd;
    else    w[15:0]  = wd;
    return w[CW-1:0];
  endfunction

  cnt_t        counter_q, counter_d;
  cnt_t        counter_prev_q, counter_prev_d;
  cnt_t        period_q, period_d;
  cnt_t        thresh_q, thresh_d;
  cnt_t        snap_q, snap_d;
  logic        to_q, to_d;
  logic        warn_q, warn_d;
  logic        early_q, early_d;
  logic        run_q, run_d;
  logic        ito_q, ito_d;
  logic        iwarn_q, iwarn_d;
  logic        force_reload_q, force_reload_d;
  logic [7:0]  pulse_q, pulse_d;
  logic [15:0] readdata_q, readdata_d;

  logic        wr_en;
  logic        kick;
  logic        early_kick;
  logic        timeout_ev;
  logic        warn_ev;
  cnt_t        reload_val;
  logic [31:0] period_w, snap_w, thresh_w;

  assign wr_en      = chipselect & ~write_n;
  assign kick       = wr_en & ((address == A_PER_L) | (address == A_PER_H));
  assign reload_val = (period_q == '0) ? cnt_t'(1) : period_q;
  assign timeout_ev = run_q & (counter_q == '0) & (counter_prev_q != '0);
  assign warn_ev    = run_q & (thresh_q != '0) & (counter_q == thresh_q) &
                      (counter_prev_q != thresh_q);

`ifdef WDOG_TIMER_WINDOW_EN
  // A kick while the counter is still above the threshold is too early and counts as a fault.
  assign early_kick = kick & run_q & (thresh_q != '0) & (counter_q > thresh_q);
`else
  assign early_kick = 1'b0;
`endif

  assign period_w = 32'(period_q);
  assign snap_w   = 32'(snap_q);
  assign thresh_w = 32'(thresh_q);

  // Next-state for all registers: bus writes, counting, event flags, pulse stretcher, read mux.
  always_comb begin
    counter_d      = counter_q;
    counter_prev_d = counter_q;
    period_d       = period_q;
    thresh_d       = thresh_q;
    snap_d         = snap_q;
    to_d           = to_q;
    warn_d         = warn_q;
    early_d        = early_q;
    run_d          = run_q;
    ito_d          = ito_q;
    iwarn_d        = iwarn_q;
    force_reload_d = kick;
    pulse_d        = pulse_q;
    readdata_d     = 16'h0000;

    // Write-1-to-clear first, so a same-cycle event below wins.
    if (wr_en && address == A_STATUS) begin
      if (writedata[0]) to_d    = 1'b0;
      if (writedata[2]) warn_d  = 1'b0;
      if (writedata[3]) early_d = 1'b0;
    end
    if (timeout_ev || early_kick) to_d    = 1'b1;
    if (warn_ev)                  warn_d  = 1'b1;
    if (early_kick)               early_d = 1'b1;

    if (wr_en && address == A_CONTROL) begin
      ito_d   = writedata[0];
      iwarn_d = writedata[1];
      if (writedata[2]) run_d = 1'b1;
    end

    if (wr_en && address == A_PER_L) period_d = write_half(period_q, 1'b0, writedata);
    if (wr_en && address == A_PER_H) period_d = write_half(period_q, 1'b1, writedata);
    if (wr_en && address == A_THR_L) thresh_d = write_half(thresh_q, 1'b0, writedata);
    if (wr_en && address == A_THR_H) thresh_d = write_half(thresh_q, 1'b1, writedata);
    if (wr_en && (address == A_SNAP_L || address == A_SNAP_H)) snap_d = counter_q;

    // A kick reloads one cycle after the PERIOD write, even when not running.
    if (force_reload_q)            counter_d = reload_val;
    else if (run_q) begin
      if (counter_q == '0)         counter_d = reload_val;
      else                         counter_d = counter_q - cnt_t'(1);
    end

    if (timeout_ev || early_kick) pulse_d = PULSE_LOAD;
    else if (pulse_q != 8'd0)     pulse_d = pulse_q - 8'd1;

    case (address)
      A_STATUS:  readdata_d = {12'h000, early_q, warn_q, run_q, to_q};
      A_CONTROL: readdata_d = {14'h0000, iwarn_q, ito_q};
      A_PER_L:   readdata_d = period_w[15:0];
      A_PER_H:   readdata_d = period_w[31:16];
      A_SNAP_L:  readdata_d = snap_w[15:0];
      A_SNAP_H:  readdata_d = snap_w[31:16];
      A_THR_L:   readdata_d = thresh_w[15:0];
      A_THR_H:   readdata_d = thresh_w[31:16];
      default:   readdata_d = 16'h0000;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q      <= DEF_PERIOD;
      counter_prev_q <= DEF_PERIOD;
      period_q       <= DEF_PERIOD;
      thresh_q       <= '0;
      snap_q         <= '0;
      to_q           <= 1'b0;
      warn_q         <= 1'b0;
      early_q        <= 1'b0;
      run_q          <= 1'b0;
      ito_q          <= 1'b0;
      iwarn_q        <= 1'b0;
      force_reload_q <= 1'b0;
      pulse_q        <= 8'd0;
      readdata_q     <= 16'h0000;
    end else begin
      counter_q      <= counter_d;
      counter_prev_q <= counter_prev_d;
      period_q       <= period_d;
      thresh_q       <= thresh_d;
      snap_q         <= snap_d;
      to_q           <= to_d;
      warn_q         <= warn_d;
      early_q        <= early_d;
      run_q          <= run_d;
      ito_q          <= ito_d;
      iwarn_q        <= iwarn_d;
      force_reload_q <= force_reload_d;
      pulse_q        <= pulse_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign irq          = (to_q & ito_q) | (warn_q & iwarn_q);
  assign resetrequest = (pulse_q != 8'd0);

endmodule

// File: doc/wdog_timer_param.md
Name: wdog_timer_param

Overview:
- Parametrised next-generation watchdog timer: Avalon-MM slave with 16-bit data and 3-bit word address.
- Adds four things the fixed-period watchdog lacks: software-programmable period, early-warning threshold interrupt, configurable-length reset-request pulse, and counter width set by parameter.
- Sits on the system peripheral bus; resetrequest feeds the system reset controller, irq feeds the CPU interrupt controller.

Parameters:
- COUNTER_WIDTH, 27: down-counter width, legal range 8..32.
- DEFAULT_PERIOD, 27'h5F5E0FF: period and counter value after reset; truncated to COUNTER_WIDTH.
- RESET_PULSE_CYCLES, 4: resetrequest high time in clk cycles, legal range 1..255.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  interrupt request, level.
- resetrequest  out  1  system reset request.

Behaviour:
- Register map:
  - 0 STATUS: bit0 TO, bit1 RUN (read-only), bit2 WARN, bit3 EARLY. Writing 1 to TO, WARN or EARLY clears that bit.
  - 1 CONTROL: bit0 ITO, bit1 IWARN. Bit2 is START, a write-only strobe.
  - 2/3 PERIOD low/high.
  - 4/5 SNAP low/high.
  - 6/7 WARN_THRESH low/high.
- Registers are 32 bits built from halves. Bits at or above COUNTER_WIDTH are not stored and read as 0.
- Write strobe = chipselect & ~write_n & address match.
- Read: readdata <= mux(address) every cycle, so latency is 1 clk. Unmapped bits read 0. readdata resets to 0.
- Reset values:
  - counter = period = DEFAULT_PERIOD.
  - WARN_THRESH = 0; all flags, control bits and RUN = 0.
  - pulse counter = 0; irq = 0; resetrequest = 0.
- RUN: set by a CONTROL write with writedata[2]=1. There is no stop; RUN clears only on reset_n.
- Kick: any PERIOD low/high write.
  - The half is written the same cycle; force_reload is registered.
  - The counter loads the new period on the following cycle, with or without RUN.
  - Writing both halves back-to-back reloads twice; the final value wins.
- Counting: when RUN and not force_reload, decrement each clk. At 0, reload the period on the next clk.
- Period value 0 loads as 1.
- Timeout event = RUN & counter==0 & counter was nonzero the previous cycle.
  - Sets TO.
  - Loads the pulse counter with RESET_PULSE_CYCLES.
- resetrequest = (pulse counter != 0). The pulse counter decrements to 0. A new timeout during a pulse restarts the count.
- Warning event = RUN & WARN_THRESH!=0 & counter==WARN_THRESH & counter was not equal to it the previous cycle. It sets WARN.
- Flag set/clear collision: an event in the same cycle as a write-1-clear leaves the flag set (event wins).
- SNAP write (either half): counter_snapshot <= counter. Reads return the snapshot.
- irq = (TO & ITO) | (WARN & IWARN). It is combinational from registers and has no extra latency.
- reset_n assertion mid-count or mid-pulse returns all state to reset values immediately, asynchronously.

Optional Feature:
- Macro: WDOG_TIMER_WINDOW_EN.
- Defined: windowed mode.
  - A kick while RUN and counter > WARN_THRESH (with WARN_THRESH != 0) is an early kick.
  - An early kick sets EARLY and TO the same cycle as the write.
  - It loads the pulse counter, so resetrequest asserts next cycle.
  - The period reload still occurs.
- Not defined: kicks are always accepted. EARLY reads 0. No window logic is synthesised.

Test Plan:
- Reset, COUNTER_WIDTH=27 -> read addr 0/1/2/3 return 0x0000/0x0000/0xE0FF/0x05F5, each 1 clk after the address; irq=0, resetrequest=0.
- Write PERIOD=0x0000_0010, START; no kick -> counter 16..0, TO=1 on the zero cycle; resetrequest high exactly 4 clk; with ITO=1 irq=1; write STATUS 0x1 -> TO=0, irq=0.
- PERIOD=100, WARN_THRESH=20, IWARN=1, START -> irq asserts when counter hits 20; kick (write PERIOD_L=100) at counter 10 -> counter reloads to 100, no TO, no resetrequest.
- Timeout coincident with a STATUS write of 0x1 -> TO stays 1; PERIOD write of 0 -> counter loads 1, timeouts every 2 clk while running.
- SNAP write at counter=0x1234 -> SNAP_L read = 0x1234, SNAP_H = 0; reset_n pulse mid resetrequest -> resetrequest=0 immediately, RUN=0.
- WDOG_TIMER_WINDOW_EN: PERIOD=100, WARN_THRESH=30, kick at counter 50 -> EARLY=1, TO=1, resetrequest 4 clk; kick at counter 25 -> accepted, no flags.
